// File: rtl/alu_multicycle_pkg.sv
// Shared types for the multi-cycle ALU: operation codes and FSM states.
package alu_multicycle_pkg;

  typedef enum logic [2:0] {AND, ADD, XOR, SUB, OR, SLL, SRL, MUL} alu_op_e;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} alu_state_e;

endpackage

// File: rtl/alu_comb_unit.sv
// Single-cycle part of the ALU: AND/ADD/XOR/SUB/OR with carry and signed overflow.
module alu_comb_unit
  import alu_multicycle_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  alu_op_e          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow
);

  localparam int MSB = WIDTH - 1;

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  assign sum  = {1'b0, a} + {1'b0, b};
  // The top bit of the extended difference is the borrow, i.e. a < b.
  assign diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    result   = '0;
    carry    = 1'b0;
    overflow = 1'b0;
    case (op)
      AND: result = a & b;
      XOR: result = a ^ b;
      OR:  result = a | b;
      ADD: begin
        result   = sum[MSB:0];
        carry    = sum[WIDTH];
        overflow = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
      end
      SUB: begin
        result   = diff[MSB:0];
        carry    = diff[WIDTH];
        overflow = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_multicycle.sv
// Multi-cycle ALU with valid/ready handshakes; shifts and multiply iterate one bit per cycle.
// state | meaning
// IDLE  | InReady high, waiting for an operand handshake
// EXEC  | iterating a shift (n steps) or multiply (WIDTH steps)
// DONE  | OutValid high, result held until OutReady
module alu_multicycle
  import alu_multicycle_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             ResetN,
  input  logic             InValid,
  output logic             InReady,
  input  logic [2:0]       ALUOp,
  input  logic [WIDTH-1:0] ALUSrcA,
  input  logic [WIDTH-1:0] ALUSrcB,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] Result,
  output logic             Carry,
  output logic             Overflow,
  output logic             Zero
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = SHW + 1;

  alu_state_e         state;
  alu_op_e            in_op;
  alu_op_e            op_q;
  logic [WIDTH-1:0]   a_q;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;

  logic [WIDTH-1:0]   comb_result;
  logic               comb_carry;
  logic               comb_overflow;
  logic [SHW-1:0]     amt;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   shift_next;
  logic               shift_out;
  logic               last_step;

  assign in_op   = alu_op_e'(ALUOp);
  assign amt     = ALUSrcB[SHW-1:0];
  assign InReady = (state == IDLE);

  alu_comb_unit #(.WIDTH(WIDTH)) u_comb (
    .op       (in_op),
    .a        (ALUSrcA),
    .b        (ALUSrcB),
    .result   (comb_result),
    .carry    (comb_carry),
    .overflow (comb_overflow)
  );

  // Multiplier lives in the low half of acc; its LSB selects the add, then the whole thing shifts right.
  assign mul_sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? a_q : '0)};
  assign acc_next   = {mul_sum, acc[WIDTH-1:1]};
  assign shift_next = (op_q == SLL) ? (a_q << 1) : (a_q >> 1);
  assign shift_out  = (op_q == SLL) ? a_q[WIDTH-1] : a_q[0];
  assign last_step  = (cnt == CW'(1));

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state    <= IDLE;
      op_q     <= AND;
      a_q      <= '0;
      cnt      <= '0;
      acc      <= '0;
      Result   <= '0;
      Carry    <= 1'b0;
      Overflow <= 1'b0;
      Zero     <= 1'b0;
      OutValid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (InValid) begin
            op_q <= in_op;
            a_q  <= ALUSrcA;
            case (in_op)
              SLL, SRL: begin
                if (amt == '0) begin
                  Result   <= ALUSrcA;
                  Carry    <= 1'b0;
                  Overflow <= 1'b0;
                  Zero     <= (ALUSrcA == '0);
                  OutValid <= 1'b1;
                  state    <= DONE;
                end else begin
                  cnt   <= CW'(amt);
                  state <= EXEC;
                end
              end
              MUL: begin
                cnt   <= CW'(WIDTH);
                acc   <= {{WIDTH{1'b0}}, ALUSrcB};
                state <= EXEC;
              end
              default: begin
                Result   <= comb_result;
                Carry    <= comb_carry;
                Overflow <= comb_overflow;
                Zero     <= (comb_result == '0);
                OutValid <= 1'b1;
                state    <= DONE;
              end
            endcase
          end
        end
        EXEC: begin
          cnt <= cnt - CW'(1);
          if (op_q == MUL) begin
            acc <= acc_next;
            if (last_step) begin
              Result   <= acc_next[WIDTH-1:0];
              Carry    <= |acc_next[2*WIDTH-1:WIDTH];
              Overflow <= 1'b0;
              Zero     <= (acc_next[WIDTH-1:0] == '0);
              OutValid <= 1'b1;
              state    <= DONE;
            end
          end else begin
            a_q <= shift_next;
            if (last_step) begin
              Result   <= shift_next;
              Carry    <= shift_out;
              Overflow <= 1'b0;
              Zero     <= (shift_next == '0);
              OutValid <= 1'b1;
              state    <= DONE;
            end
          end
        end
        DONE: begin
          if (OutReady) begin
            OutValid <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
